// File: rtl/id_ex_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage: ALU opcodes, operand selects
// and default widths.
package id_ex_operand_stage_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned RA_W_DEF = 5;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_OR    = 4'd6,
    ALU_AND   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_PASSA = 4'd11,
    ALU_PASSB = 4'd12
  } alu_op_e;

  localparam logic ASEL_RS1 = 1'b0;
  localparam logic ASEL_PC  = 1'b1;
  localparam logic BSEL_RS2 = 1'b0;
  localparam logic BSEL_IMM = 1'b1;

  // A bubble must never present a live opcode to the ALU.
  function automatic logic [3:0] gate_ctr(input logic valid, input logic [3:0] ctr);
    return valid ? ctr : 4'(ALU_ADD);
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Forwarding mux for one source operand: picks EX/MEM, then MEM/WB, then the
// registered register-file value; x0 always reads zero.
module id_ex_operand_stage_fwd_mux
  import id_ex_operand_stage_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned RA_W   = RA_W_DEF,
  parameter int unsigned FWD_EN = 1
) (
  input  logic [RA_W-1:0] rs,
  input  logic [XLEN-1:0] reg_data,
  input  logic            exm_valid,
  input  logic            exm_reg_we,
  input  logic [RA_W-1:0] exm_rd,
  input  logic [XLEN-1:0] exm_result,
  input  logic            wb_valid,
  input  logic            wb_reg_we,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] fwd_data
);

  logic rs_zero;
  logic exm_hit;
  logic wb_hit;

  assign rs_zero = (rs == '0);
  assign exm_hit = (FWD_EN != 0) && exm_valid && exm_reg_we && (exm_rd == rs) && !rs_zero;
  assign wb_hit  = (FWD_EN != 0) && wb_valid && wb_reg_we && (wb_rd == rs) && !rs_zero;

  always_comb begin
    fwd_data = reg_data;
    if (rs_zero)      fwd_data = '0;
    else if (exm_hit) fwd_data = exm_result;
    else if (wb_hit)  fwd_data = wb_result;
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-side forwarding and ALU operand selection.
// Flush beats stall; a stall re-captures forwarded source data so late WB results survive.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned RA_W   = RA_W_DEF,
  parameter int unsigned FWD_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [3:0]      id_alu_ctr,
  input  logic            id_a_sel,
  input  logic            id_b_sel,
  input  logic            id_reg_we,
  input  logic            exm_valid,
  input  logic            exm_reg_we,
  input  logic [RA_W-1:0] exm_rd,
  input  logic [XLEN-1:0] exm_result,
  input  logic            wb_valid,
  input  logic            wb_reg_we,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic            ex_valid,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [3:0]      alu_ctr,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_reg_we,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_pc
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] imm_q;
  logic [RA_W-1:0] rs1_q;
  logic [RA_W-1:0] rs2_q;
  logic [RA_W-1:0] rd_q;
  logic [3:0]      ctr_q;
  logic            a_sel_q;
  logic            b_sel_q;
  logic            reg_we_q;

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  id_ex_operand_stage_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W), .FWD_EN(FWD_EN)) u_fwd_rs1 (
    .rs         (rs1_q),
    .reg_data   (rs1_data_q),
    .exm_valid  (exm_valid),
    .exm_reg_we (exm_reg_we),
    .exm_rd     (exm_rd),
    .exm_result (exm_result),
    .wb_valid   (wb_valid),
    .wb_reg_we  (wb_reg_we),
    .wb_rd      (wb_rd),
    .wb_result  (wb_result),
    .fwd_data   (fwd_rs1)
  );

  id_ex_operand_stage_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W), .FWD_EN(FWD_EN)) u_fwd_rs2 (
    .rs         (rs2_q),
    .reg_data   (rs2_data_q),
    .exm_valid  (exm_valid),
    .exm_reg_we (exm_reg_we),
    .exm_rd     (exm_rd),
    .exm_result (exm_result),
    .wb_valid   (wb_valid),
    .wb_reg_we  (wb_reg_we),
    .wb_rd      (wb_rd),
    .wb_result  (wb_result),
    .fwd_data   (fwd_rs2)
  );

  // Bubbles clear every field so data outputs stay deterministic (x0 reads 0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      ctr_q      <= 4'(ALU_ADD);
      a_sel_q    <= ASEL_RS1;
      b_sel_q    <= BSEL_RS2;
      reg_we_q   <= 1'b0;
    end else if (stall) begin
      rs1_data_q <= fwd_rs1;
      rs2_data_q <= fwd_rs2;
    end else begin
      valid_q    <= id_valid;
      pc_q       <= id_pc;
      rs1_data_q <= id_rs1_data;
      rs2_data_q <= id_rs2_data;
      imm_q      <= id_imm;
      rs1_q      <= id_rs1;
      rs2_q      <= id_rs2;
      rd_q       <= id_rd;
      ctr_q      <= id_alu_ctr;
      a_sel_q    <= id_a_sel;
      b_sel_q    <= id_b_sel;
      reg_we_q   <= id_reg_we;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_reg_we     = valid_q & reg_we_q;
  assign alu_ctr       = gate_ctr(valid_q, ctr_q);
  assign ex_rd         = rd_q;
  assign ex_pc         = pc_q;
  assign alu_in1       = (a_sel_q == ASEL_PC) ? pc_q : fwd_rs1;
  assign alu_in2       = (b_sel_q == BSEL_IMM) ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;

endmodule
